// File: rtl/i2s_rx_deser.sv
// I2S slave receiver: oversamples sck/lrclk/sdin on m_clk, deserialises
// Philips-format stereo frames and emits one data_valid pulse per good
// L/R frame, or one frame_err pulse per discarded frame.
module i2s_rx_deser #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int CW      = 6
) (
    input  logic          m_clk,
    input  logic          rst,
    input  logic          i2s_sck,
    input  logic          i2s_lrclk,
    input  logic          i2s_sdin,
    output logic [DW-1:0] left_data,
    output logic [DW-1:0] right_data,
    output logic          data_valid,
    output logic          frame_err,
    output logic          locked
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t state, state_next;

    logic sck_s1, sck_s2, sck_s3;
    logic lr_s1, lr_s2;
    logic sd_s1, sd_s2;
    logic lr_prev;

    logic [DW-1:0] shreg;
    logic [DW-1:0] word;
    logic [DW-1:0] left_hold;
    logic [DW-1:0] right_hold;
    logic [CW-1:0] cnt;
    logic [TW-1:0] idle_cnt;
    logic          l_ok;
    logic          commit_ok;
    logic          commit_bad;

    logic rise;
    logic lr_edge;
    logic nbits_ok;
    logic tmo;
    logic load_left;
    logic frame_ok;
    logic frame_bad;

    assign rise     = sck_s2 & ~sck_s3;
    assign lr_edge  = rise & (lr_s2 != lr_prev);
    assign word     = {shreg[DW-2:0], sd_s2};
    assign nbits_ok = (cnt == CW'(DW - 1));
    assign tmo      = (idle_cnt == TW'(TIMEOUT)) & ~rise;
    assign locked   = (state != IDLE);

    // Two-flop synchronisers plus the delayed sck copy used for edge detection.
    always_ff @(posedge m_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, which is what a synchroniser chain needs.
        if (rst) begin
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_s3 <= 1'b0;
            lr_s1  <= 1'b0;
            lr_s2  <= 1'b0;
            sd_s1  <= 1'b0;
            sd_s2  <= 1'b0;
        end else begin
            sck_s1 <= i2s_sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            lr_s1  <= i2s_lrclk;
            lr_s2  <= lr_s1;
            sd_s1  <= i2s_sdin;
            sd_s2  <= sd_s1;
        end
    end

    // Frame state register.
    always_ff @(posedge m_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and one-cycle close/abort strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_next = state;
        load_left  = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        unique case (state)
            IDLE: begin
                // Only a right-to-left transition arms; its closing bit is dropped.
                if (lr_edge && lr_prev) state_next = LEFT;
            end
            LEFT: begin
                if (lr_edge) begin
                    load_left  = 1'b1;
                    state_next = RIGHT;
                end else if (tmo) begin
                    frame_bad  = 1'b1;
                    state_next = IDLE;
                end
            end
            RIGHT: begin
                if (lr_edge) begin
                    state_next = LEFT;
                    if (l_ok && nbits_ok) frame_ok  = 1'b1;
                    else                  frame_bad = 1'b1;
                end else if (tmo) begin
                    frame_bad  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register, slot counter and sck-activity watchdog.
    always_ff @(posedge m_clk) begin
        if (rst) begin
            shreg    <= '0;
            cnt      <= '0;
            idle_cnt <= '0;
            lr_prev  <= 1'b0;
        end else begin
            if (rise) begin
                lr_prev  <= lr_s2;
                idle_cnt <= '0;
                if (lr_edge) begin
                    cnt <= '0;
                end else begin
                    shreg <= word;
                    if (cnt != {CW{1'b1}}) cnt <= cnt + CW'(1);
                end
            end else if (idle_cnt != TW'(TIMEOUT)) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

    // Word capture on channel close; commit strobes for the output stage.
    always_ff @(posedge m_clk) begin
        if (rst) begin
            left_hold  <= '0;
            right_hold <= '0;
            l_ok       <= 1'b0;
            commit_ok  <= 1'b0;
            commit_bad <= 1'b0;
        end else begin
            if (load_left) begin
                left_hold <= word;
                l_ok      <= nbits_ok;
            end else if (state_next == IDLE) begin
                l_ok <= 1'b0;
            end
            if (frame_ok) right_hold <= word;
            commit_ok  <= frame_ok;
            commit_bad <= frame_bad;
        end
    end

    // Output stage: publish a good frame or flag a discarded one.
    always_ff @(posedge m_clk) begin
        if (rst) begin
            left_data  <= '0;
            right_data <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= commit_ok;
            frame_err  <= commit_bad;
            if (commit_ok) begin
                left_data  <= left_hold;
                right_data <= right_hold;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Scoreboard bench for i2s_rx_deser: the stimulus side pushes expected
// frame outcomes, a negedge monitor pops and compares on each pulse.
module tb_i2s_rx_deser;

    localparam int DW = 32;

    logic          m_clk;
    logic          rst;
    logic          i2s_sck;
    logic          i2s_lrclk;
    logic          i2s_sdin;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          data_valid;
    logic          frame_err;
    logic          locked;

    i2s_rx_deser #(.DW(DW), .TIMEOUT(64), .CW(6)) dut (
        .m_clk      (m_clk),
        .rst        (rst),
        .i2s_sck    (i2s_sck),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sdin   (i2s_sdin),
        .left_data  (left_data),
        .right_data (right_data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .locked     (locked)
    );

    typedef struct {
        logic          is_err;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   valid_cyc[$];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_rise_cycle = 0;
    int            err_cyc = -100000;
    int            dly = 2;
    logic          pending_lsb = 1'b0;
    logic [DW-1:0] good_l = '0;
    logic [DW-1:0] good_r = '0;
    logic [DW-1:0] prev_l = '0;
    logic [DW-1:0] prev_r = '0;

    initial begin
        m_clk = 1'b0;
        forever #10 m_clk = ~m_clk;
    end

    always @(posedge m_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, val, lo, hi, cyc);
        end
    endtask

    // Monitor: pops one expectation per data_valid/frame_err pulse.
    always @(negedge m_clk) begin
        if (data_valid && frame_err) check("valid_and_err_together", 1, 0);
        if (data_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {data_valid, frame_err}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind_is_err", frame_err, e.is_err);
                check(e.is_err ? "held_left" : "left_data", left_data, e.l);
                check(e.is_err ? "held_right" : "right_data", right_data, e.r);
                if (data_valid) begin
                    check_range("valid_latency", cyc - last_rise_cycle, 4, 5);
                    valid_cyc.push_back(cyc);
                end else begin
                    err_cyc = cyc;
                end
            end
        end
        if (!rst && (left_data !== prev_l)) check("left_change_on_valid", data_valid, 1);
        if (!rst && (right_data !== prev_r)) check("right_change_on_valid", data_valid, 1);
        prev_l = left_data;
        prev_r = right_data;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge m_clk);
        #dly;
    endtask

    // One BCLK slot: data and word select change with the falling sck edge.
    task automatic send_slot(input logic lr, input logic b);
        i2s_sck   = 1'b0;
        i2s_lrclk = lr;
        i2s_sdin  = b;
        wait_cycles(8);
        i2s_sck = 1'b1;
        last_rise_cycle = cyc;
        wait_cycles(8);
    endtask

    // A channel of len slots: the previous word's LSB, then bits len-1..1.
    task automatic send_channel(input logic lr, input logic [DW-1:0] w, input int len);
        send_slot(lr, pending_lsb);
        for (int i = len - 1; i >= 1; i--) send_slot(lr, w[i]);
        pending_lsb = w[0];
    endtask

    task automatic push_valid(input logic [DW-1:0] l, input logic [DW-1:0] r);
        exp_t e;
        e.is_err = 1'b0;
        e.l = l;
        e.r = r;
        exp_q.push_back(e);
        good_l = l;
        good_r = r;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.l = good_l;
        e.r = good_r;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        send_channel(1'b0, l, DW);
        send_channel(1'b1, r, DW);
        push_valid(l, r);
    endtask

    initial begin
        rst       = 1'b1;
        i2s_sck   = 1'b0;
        i2s_lrclk = 1'b1;
        i2s_sdin  = 1'b0;
        wait_cycles(4);

        // Reset state.
        check("reset_left", left_data, 0);
        check("reset_right", right_data, 0);
        check("reset_valid", data_valid, 0);
        check("reset_err", frame_err, 0);
        check("reset_locked", locked, 0);
        rst = 1'b0;
        wait_cycles(4);

        // First frame: the 1->0 edge arms, the completed frame is reported.
        send_channel(1'b1, 32'h0F0F_0000, DW);
        check("idle_before_arm", locked, 0);
        send_channel(1'b0, 32'h8000_0001, DW);
        check("locked_in_left", locked, 1);
        send_channel(1'b1, 32'h7FFF_FFFE, DW);
        check("locked_in_right", locked, 1);
        push_valid(32'h8000_0001, 32'h7FFF_FFFE);

        // Streamed frames.
        send_frame(32'h0000_0001, 32'hFFFF_FFFF);
        send_frame(32'hFFFF_FFFE, 32'h0000_0002);
        send_frame(32'h1234_5678, 32'hFEDC_BA98);
        send_frame(32'h0000_0000, 32'h0000_0000);

        // Short right channel between two good frames.
        send_frame(32'hCAFE_F00D, 32'h0000_BEEF);
        check("valid_count_after_stream", valid_cyc.size(), 5);
        if (valid_cyc.size() >= 5) begin
            for (int i = 2; i <= 4; i++)
                check("valid_spacing", valid_cyc[i] - valid_cyc[i-1], 1024);
        end
        send_channel(1'b0, 32'h0BAD_0BAD, DW);
        send_channel(1'b1, 32'h1111_1111, DW - 1);
        push_err();
        send_frame(32'h1357_9BDF, 32'h2468_ACE0);

        // sck stalls mid-left word.
        send_channel(1'b0, 32'hDEAD_BEEF, 11);
        push_err();
        wait_cycles(100);
        // 64 idle cycles plus synchroniser and output-stage delay.
        check_range("timeout_latency", err_cyc - last_rise_cycle, 64, 72);
        check("unlocked_after_timeout", locked, 0);
        send_channel(1'b1, 32'h5A5A_5A5A, DW);
        check("rearm_not_locked", locked, 0);
        send_frame(32'h0F0F_0F0F, 32'hF0F0_F0F0);

        // Reset mid-right word.
        send_channel(1'b0, 32'h7777_7777, DW);
        send_channel(1'b1, 32'h4444_4444, 10);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        good_l = '0;
        good_r = '0;
        check("post_rst_left", left_data, 0);
        check("post_rst_right", right_data, 0);
        check("post_rst_valid", data_valid, 0);
        check("post_rst_err", frame_err, 0);
        check("post_rst_locked", locked, 0);
        send_channel(1'b1, 32'h3C3C_3C3C, DW);
        send_frame(32'h2222_3333, 32'hCCCC_DDDD);

        // sck phase sweep against m_clk.
        for (int k = 0; k < 16; k++) begin
            dly = 1 + (k % 4) * 4;
            if (k > 0) wait_cycles(k);
            send_frame(32'hAAAA_5555, 32'h5555_AAAA);
        end

        // Close the last right word and drain.
        send_channel(1'b0, 32'h0000_0000, 2);
        wait_cycles(20);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
